plus_asic_regs: RTL and testbench
=================================

PLUS_ASIC_REGS -- requirements
Module: plus_asic_regs

Interface
REQ-001 SHALL have ports: clk in 1, system clock; all logic on its rising edge.
REQ-002 SHALL have reset_n in 1; reset is synchronous and active-low.
REQ-003 SHALL have plus_mode in 1; when 0, the block ignores writes and holds pri_irq at 0.
REQ-004 SHALL have sel in 1; ASIC page selected, meaning register page enabled and CPU address in 0x4000-0x7FFF.
REQ-005 SHALL have addr in 14; CPU address bits 13:0 within the page.
REQ-006 SHALL have din in 8; CPU write data.
REQ-007 SHALL have wr in 1 and rd in 1; active-high CPU memory strobes.
REQ-008 SHALL have dout out 8; registered read data.
REQ-009 SHALL have m1 in 1 and iorq in 1; active-high, both high = interrupt acknowledge.
REQ-010 SHALL have hsync in 1 and vsync in 1; CRTC sync outputs.
REQ-011 SHALL have pri_irq out 1 (raster interrupt request) and int_vector out 8.
REQ-012 SHALL have pal_idx in 5 and pal_rgb out 12; video palette port, {G,R,B} 4 bits each.
REQ-013 SHALL have split_line out 8, split_addr out 16, sscr out 8; raw register values.

Function
REQ-014 Write commit SHALL occur once per strobe, on the first clk where sel&wr is high after being low (edge detect).
REQ-015 Register map: 0x2400-0x243F palette; entry n = offset>>1; even byte = {R[7:4],B[3:0]}; odd byte = G in low nibble, high nibble ignored.
REQ-016 Register map: 0x2800 PRI line, 0x2801 split_line, 0x2802 split_addr high, 0x2803 split_addr low, 0x2804 sscr, 0x2805 IVR.
REQ-017 Reads SHALL return data on dout one clk after sel&rd goes high; data is held until the next read.
REQ-018 Palette reads SHALL return stored bytes, with the odd byte as {4'h0,G}.
REQ-019 Reads of all other offsets, including 0x2800-0x2805, SHALL return 0xFF.
REQ-020 The line counter SHALL be 8 bits, clear to 0 on the vsync rising edge, and increment by 1 on each hsync falling edge, wrapping 255->0.
REQ-021 If vsync rise and hsync fall coincide, clear SHALL win.
REQ-022 A PRI event SHALL occur on an hsync falling edge when pri_line != 0 and the post-increment counter equals pri_line; pri_line = 0 disables events.
REQ-023 pri_pending SHALL set on a PRI event; pri_irq = pri_pending & plus_mode.
REQ-024 On the rising edge of (m1&iorq) with pri_pending set, pri_pending SHALL clear and int_vector SHALL latch {IVR[7:3],3'b110}; int_vector is otherwise unchanged.
REQ-025 A write to 0x2800 SHALL clear pri_pending.
REQ-026 If a set and a clear (ack or 0x2800 write) occur in the same clk, set SHALL win.
REQ-027 A PRI write in the same clk as an hsync fall SHALL take effect from the next line; the old value is used for the compare in that clk.
REQ-028 pal_rgb SHALL equal palette[pal_idx] one clk later; if a write to the same entry coincides, old data SHALL be returned.

Reset
REQ-029 On reset_n = 0 at a clk edge, the block SHALL clear: line counter, pri_line, split_line, split_addr, sscr, pri_pending, dout (to 0xFF), and edge-detect state.
REQ-030 On reset, IVR SHALL be 0x00 and int_vector SHALL be 0x06.
REQ-031 Palette contents SHALL be preserved through reset; pal_rgb is reset to 0.
REQ-032 Reset mid-strobe SHALL leave no commit; a strobe still high after reset SHALL NOT commit until it falls and rises again.

Structure
REQ-033 A shared package SHALL hold the offset constants (PAL_BASE, PRI, SPLT, SSA_H, SSA_L, SSCR, IVR), the vector source code 3'b110, and widths.
REQ-034 One sub-module, plus_asic_palette, SHALL implement the 32x12 dual-port palette RAM (CPU byte write/read, video read).

Verification
REQ-035 Reset, then write 0x2800=0x05, then 0 vsync + 5 hsync pulses -> pri_irq rises within 1 clk of the 5th hsync fall; no rise earlier.
REQ-036 With pending set, IVR=0xA8, assert m1&iorq -> int_vector=0xAE and pri_irq=0 next clk.
REQ-037 Write 0x2400=0x3C and 0x2401=0xF7, then read both -> 0x3C and 0x07; pal_idx=0 gives pal_rgb=0x73C.
REQ-038 Hold wr high for 10 clk with data changing from 0x11 to 0x22 -> register = 0x11.
REQ-039 pri_line=0x00 with 300 hsync pulses -> pri_irq stays 0; pri_line=0x02 with vsync rise coinciding with hsync fall -> count restarts and event fires on the 2nd subsequent hsync fall.
REQ-040 Ack in the same clk as a new PRI event -> pri_irq remains 1; plus_mode=0 -> write to 0x2805 ignored and pri_irq=0.

Source files
------------

// File: rtl/plus_asic_regs_pkg.sv
// Shared constants for the Plus ASIC register page: offsets, widths and the
// raster interrupt vector source code.
package plus_asic_regs_pkg;
  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 8;
  localparam int RGB_W     = 12;
  localparam int PAL_DEPTH = 32;
  localparam int PAL_IDX_W = 5;

  localparam logic [ADDR_W-1:0] PAL_BASE = 14'h2400;
  localparam logic [ADDR_W-1:0] PRI      = 14'h2800;
  localparam logic [ADDR_W-1:0] SPLT     = 14'h2801;
  localparam logic [ADDR_W-1:0] SSA_H    = 14'h2802;
  localparam logic [ADDR_W-1:0] SSA_L    = 14'h2803;
  localparam logic [ADDR_W-1:0] SSCR     = 14'h2804;
  localparam logic [ADDR_W-1:0] IVR      = 14'h2805;

  localparam logic [2:0] VEC_SRC = 3'b110;
endpackage

// File: rtl/plus_asic_palette.sv
// 32x12 palette RAM: CPU byte-wide write/read port, registered video read port.
module plus_asic_palette
  import plus_asic_regs_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cpu_we,
  input  logic [5:0]           cpu_addr,
  input  logic [DATA_W-1:0]    cpu_wdata,
  output logic [DATA_W-1:0]    cpu_rdata,
  input  logic [PAL_IDX_W-1:0] vid_idx,
  output logic [RGB_W-1:0]     vid_rgb
);
  // Entry layout {G,R,B}: even byte is {R,B}, odd byte carries G in its low nibble.
  logic [RGB_W-1:0] mem [PAL_DEPTH];
  logic [RGB_W-1:0] cpu_entry;

  always_ff @(posedge clk) begin
    if (cpu_we) begin
      if (cpu_addr[0]) mem[cpu_addr[5:1]][11:8] <= cpu_wdata[3:0];
      else             mem[cpu_addr[5:1]][7:0]  <= cpu_wdata;
    end
  end

  assign cpu_entry = mem[cpu_addr[5:1]];
  assign cpu_rdata = cpu_addr[0] ? {4'h0, cpu_entry[11:8]} : cpu_entry[7:0];

  // Contents survive reset; only the video output register is cleared.
  always_ff @(posedge clk) begin
    if (!reset_n) vid_rgb <= '0;
    else          vid_rgb <= mem[vid_idx];
  end
endmodule

// File: rtl/plus_asic_regs.sv
// Plus ASIC register page: palette, raster interrupt (PRI) with line counter,
// split-screen and soft-scroll registers, interrupt vector.
module plus_asic_regs
  import plus_asic_regs_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 plus_mode,
  input  logic                 sel,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    din,
  input  logic                 wr,
  input  logic                 rd,
  output logic [DATA_W-1:0]    dout,
  input  logic                 m1,
  input  logic                 iorq,
  input  logic                 hsync,
  input  logic                 vsync,
  output logic                 pri_irq,
  output logic [7:0]           int_vector,
  input  logic [PAL_IDX_W-1:0] pal_idx,
  output logic [RGB_W-1:0]     pal_rgb,
  output logic [7:0]           split_line,
  output logic [15:0]          split_addr,
  output logic [7:0]           sscr
);
  logic       wr_q, rd_q, ack_q, hs_q, vs_q;
  logic [7:0] line_cnt, line_nxt, pri_line, ivr;
  logic       pri_pending;
  logic       wr_rise, commit, rd_rise, ack_rise, hs_fall, vs_rise;
  logic       pal_hit, pri_evt;
  logic [DATA_W-1:0] pal_rdata;

  assign wr_rise  = sel & wr & ~wr_q;
  assign commit   = wr_rise & plus_mode;
  assign rd_rise  = sel & rd & ~rd_q;
  assign ack_rise = m1 & iorq & ~ack_q;
  assign hs_fall  = hs_q & ~hsync;
  assign vs_rise  = vsync & ~vs_q;
  assign line_nxt = line_cnt + 8'd1;
  assign pal_hit  = (addr[13:6] == PAL_BASE[13:6]);
  // A coincident vsync clear wins, so the increment that would match is suppressed.
  assign pri_evt  = hs_fall & ~vs_rise & (pri_line != 8'd0) & (line_nxt == pri_line);
  assign pri_irq  = pri_pending & plus_mode;

  plus_asic_palette u_pal (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_we    (commit & pal_hit),
    .cpu_addr  (addr[5:0]),
    .cpu_wdata (din),
    .cpu_rdata (pal_rdata),
    .vid_idx   (pal_idx),
    .vid_rgb   (pal_rgb)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // Strobes look already-high so one held across reset must fall first.
      wr_q        <= 1'b1;
      rd_q        <= 1'b1;
      ack_q       <= 1'b1;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      line_cnt    <= '0;
      pri_line    <= '0;
      split_line  <= '0;
      split_addr  <= '0;
      sscr        <= '0;
      ivr         <= '0;
      pri_pending <= 1'b0;
      dout        <= 8'hFF;
      int_vector  <= {5'd0, VEC_SRC};
    end else begin
      wr_q  <= sel & wr;
      rd_q  <= sel & rd;
      ack_q <= m1 & iorq;
      hs_q  <= hsync;
      vs_q  <= vsync;

      if (vs_rise)      line_cnt <= '0;
      else if (hs_fall) line_cnt <= line_nxt;

      if (pri_evt)                                pri_pending <= 1'b1;
      else if (ack_rise || (commit && addr == PRI)) pri_pending <= 1'b0;

      if (ack_rise && pri_pending) int_vector <= {ivr[7:3], VEC_SRC};

      if (commit) begin
        case (addr)
          PRI:     pri_line         <= din;
          SPLT:    split_line       <= din;
          SSA_H:   split_addr[15:8] <= din;
          SSA_L:   split_addr[7:0]  <= din;
          SSCR:    sscr             <= din;
          IVR:     ivr              <= din;
          default: ;
        endcase
      end

      if (rd_rise) dout <= pal_hit ? pal_rdata : 8'hFF;
    end
  end
endmodule

// File: tb/tb_plus_asic_regs.sv
// Directed bench for plus_asic_regs: register/palette vector table plus
// hand-written raster interrupt, strobe and reset sequences.
module tb_plus_asic_regs;
  logic        clk = 0, reset_n = 0, plus_mode = 1, sel = 0, wr = 0, rd = 0;
  logic [13:0] addr = '0;
  logic [7:0]  din = '0, dout, int_vector, split_line, sscr;
  logic        m1 = 0, iorq = 0, hsync = 0, vsync = 0, pri_irq;
  logic [4:0]  pal_idx = '0;
  logic [11:0] pal_rgb;
  logic [15:0] split_addr;

  int n_vec = 0, n_fail = 0;

  always #5 clk = ~clk;

  plus_asic_regs dut (
    .clk(clk), .reset_n(reset_n), .plus_mode(plus_mode), .sel(sel), .addr(addr),
    .din(din), .wr(wr), .rd(rd), .dout(dout), .m1(m1), .iorq(iorq),
    .hsync(hsync), .vsync(vsync), .pri_irq(pri_irq), .int_vector(int_vector),
    .pal_idx(pal_idx), .pal_rgb(pal_rgb), .split_line(split_line),
    .split_addr(split_addr), .sscr(sscr)
  );

  typedef struct {
    logic        is_rd;
    logic [13:0] a;
    logic [7:0]  d;   // write data, or expected read data
  } vec_t;
  vec_t vecs [16];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cpu_write(input logic [13:0] a, input logic [7:0] d);
    @(negedge clk); sel = 1; wr = 1; addr = a; din = d;
    @(negedge clk); sel = 0; wr = 0;
    @(negedge clk);
  endtask

  task automatic cpu_read(input logic [13:0] a, output logic [7:0] d);
    @(negedge clk); sel = 1; rd = 1; addr = a;
    @(negedge clk); d = dout; sel = 0; rd = 0;
    @(negedge clk);
  endtask

  task automatic hs_pulse();
    @(negedge clk); hsync = 1;
    @(negedge clk); hsync = 0;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] rdat;
    logic       any_irq;

    vecs[0]  = '{1'b0, 14'h2400, 8'h3C};
    vecs[1]  = '{1'b0, 14'h2401, 8'hF7};
    vecs[2]  = '{1'b0, 14'h243E, 8'hA5};
    vecs[3]  = '{1'b0, 14'h243F, 8'h5B};
    vecs[4]  = '{1'b0, 14'h2801, 8'h9A};
    vecs[5]  = '{1'b0, 14'h2802, 8'h12};
    vecs[6]  = '{1'b0, 14'h2803, 8'h34};
    vecs[7]  = '{1'b0, 14'h2804, 8'h56};
    vecs[8]  = '{1'b1, 14'h2400, 8'h3C};
    vecs[9]  = '{1'b1, 14'h2401, 8'h07};
    vecs[10] = '{1'b1, 14'h243E, 8'hA5};
    vecs[11] = '{1'b1, 14'h243F, 8'h0B};
    vecs[12] = '{1'b1, 14'h2800, 8'hFF};
    vecs[13] = '{1'b1, 14'h2805, 8'hFF};
    vecs[14] = '{1'b1, 14'h0000, 8'hFF};
    vecs[15] = '{1'b1, 14'h2440, 8'hFF};

    repeat (3) @(negedge clk);
    chk("rst_dout", {8'h0, dout}, 16'h00FF);
    chk("rst_ivec", {8'h0, int_vector}, 16'h0006);
    chk("rst_irq", {15'h0, pri_irq}, 16'h0);
    chk("rst_pal_rgb", {4'h0, pal_rgb}, 16'h0);
    chk("rst_split", split_addr, 16'h0);
    reset_n = 1;

    foreach (vecs[i]) begin
      if (vecs[i].is_rd) begin
        cpu_read(vecs[i].a, rdat);
        chk($sformatf("rd_%h", vecs[i].a), {8'h0, rdat}, {8'h0, vecs[i].d});
      end else begin
        cpu_write(vecs[i].a, vecs[i].d);
      end
    end
    chk("split_line", {8'h0, split_line}, 16'h009A);
    chk("split_addr", split_addr, 16'h1234);
    chk("sscr", {8'h0, sscr}, 16'h0056);
    @(negedge clk); @(negedge clk);
    chk("pal_rgb_0", {4'h0, pal_rgb}, 16'h073C);
    pal_idx = 5'd31;
    @(negedge clk);
    chk("pal_rgb_31", {4'h0, pal_rgb}, 16'h0BA5);
    pal_idx = 5'd0;

    // Held write strobe commits only the first data byte.
    @(negedge clk); sel = 1; wr = 1; addr = 14'h2801; din = 8'h11;
    @(negedge clk); din = 8'h22;
    repeat (8) @(negedge clk);
    sel = 0; wr = 0;
    @(negedge clk);
    chk("held_wr", {8'h0, split_line}, 16'h0011);

    // Reset in the middle of a strobe: no commit until the strobe re-arms.
    @(negedge clk); reset_n = 0; sel = 1; wr = 1; addr = 14'h2804; din = 8'h77;
    @(negedge clk);
    chk("rst_pal_rgb2", {4'h0, pal_rgb}, 16'h0);
    reset_n = 1;
    repeat (3) @(negedge clk);
    chk("rst_mid_strobe", {8'h0, sscr}, 16'h0);
    chk("pal_kept", {4'h0, pal_rgb}, 16'h073C);
    wr = 0;
    @(negedge clk); wr = 1;
    @(negedge clk); wr = 0; sel = 0;
    @(negedge clk);
    chk("rearm_wr", {8'h0, sscr}, 16'h0077);

    // PRI on line 5.
    cpu_write(14'h2800, 8'h05);
    for (int i = 1; i <= 5; i++) begin
      hs_pulse();
      chk($sformatf("pri5_line%0d", i), {15'h0, pri_irq}, {15'h0, (i == 5)});
    end

    // Acknowledge with IVR=0xA8.
    cpu_write(14'h2805, 8'hA8);
    chk("pend_after_ivr", {15'h0, pri_irq}, 16'h1);
    @(negedge clk); m1 = 1; iorq = 1;
    @(negedge clk); m1 = 0; iorq = 0;
    chk("ack_ivec", {8'h0, int_vector}, 16'h00AE);
    chk("ack_irq", {15'h0, pri_irq}, 16'h0);

    // pri_line=0 disables events.
    cpu_write(14'h2800, 8'h00);
    any_irq = 0;
    for (int i = 0; i < 300; i++) begin
      hs_pulse();
      any_irq |= pri_irq;
    end
    chk("pri0_no_irq", {15'h0, any_irq}, 16'h0);

    // vsync rise coinciding with hsync fall restarts the count.
    cpu_write(14'h2800, 8'h02);
    @(negedge clk); hsync = 1;
    @(negedge clk); hsync = 0; vsync = 1;
    @(negedge clk); vsync = 0;
    chk("vs_hs_clear", {15'h0, pri_irq}, 16'h0);
    hs_pulse();
    chk("pri2_line1", {15'h0, pri_irq}, 16'h0);
    hs_pulse();
    chk("pri2_line2", {15'h0, pri_irq}, 16'h1);

    // Ack coinciding with a new event: set wins.
    @(negedge clk); vsync = 1;
    @(negedge clk); vsync = 0;
    hs_pulse();
    @(negedge clk); hsync = 1;
    @(negedge clk); hsync = 0; m1 = 1; iorq = 1;
    @(negedge clk); m1 = 0; iorq = 0;
    chk("ack_vs_set", {15'h0, pri_irq}, 16'h1);

    // plus_mode=0 masks the request and ignores writes.
    plus_mode = 0;
    @(negedge clk);
    chk("mode0_irq", {15'h0, pri_irq}, 16'h0);
    cpu_write(14'h2805, 8'h55);
    plus_mode = 1;
    @(negedge clk);
    chk("mode1_irq", {15'h0, pri_irq}, 16'h1);
    @(negedge clk); m1 = 1; iorq = 1;
    @(negedge clk); m1 = 0; iorq = 0;
    chk("mode0_ivr_ign", {8'h0, int_vector}, 16'h00AE);

    // Palette write coinciding with video read returns old data first.
    @(negedge clk); sel = 1; wr = 1; addr = 14'h2400; din = 8'h11;
    @(negedge clk); sel = 0; wr = 0;
    chk("pal_coinc_old", {4'h0, pal_rgb}, 16'h073C);
    @(negedge clk);
    chk("pal_coinc_new", {4'h0, pal_rgb}, 16'h0711);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
